dnn_classify_ctrl: RTL
======================

DNN_CLASSIFY_CTRL -- requirements
Module: dnn_classify_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 17, memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 15, signed fixed-point score width.
REQ-003 The block SHALL have parameter NUM_CLASSES, default 10, number of engine outputs scanned.
REQ-004 The block SHALL have parameter TIMEOUT, default 1000000, maximum WAIT-state cycles before abort.
REQ-005 The block SHALL have ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- req  in  1  request to classify one image
- img_base  in  ADDR_WIDTH  image base address, captured on accept
- busy  out  1  high whenever state is not IDLE
- eng_reset  out  1  active-high soft clear to the engine
- eng_start  out  1  start pulse to the engine
- eng_done  in  1  engine completion level
- eng_addr  in  ADDR_WIDTH  engine-relative memory address
- mem_addr  out  ADDR_WIDTH  absolute memory address
- out_idx  out  4  engine output select
- eng_out  in  DATA_WIDTH signed  selected engine score, combinational from out_idx
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_class  out  4  argmax class, 15 on error
- res_score  out  DATA_WIDTH signed  winning score, 0 on error
- res_err  out  1  timeout abort flag

Function
REQ-006 The FSM SHALL have states IDLE, CLR, START, WAIT, SCAN, RESULT.
REQ-007 In IDLE, req=1 SHALL be accepted: img_base registered into base_q, next state CLR; req in any other state SHALL be ignored.
REQ-008 CLR SHALL last exactly one cycle with eng_reset=1, then go to START.
REQ-009 START SHALL last exactly one cycle with eng_start=1, clear the timeout counter, then go to WAIT.
REQ-010 eng_reset and eng_start SHALL be 0 in every state other than CLR and START respectively.
REQ-011 In WAIT, eng_done=1 SHALL move to SCAN with out_idx=0, best index=0, best score=most negative DATA_WIDTH value.
REQ-012 In WAIT, the counter SHALL increment each cycle; on reaching TIMEOUT-1 without eng_done, the FSM SHALL go to RESULT with res_err=1, res_class=15, res_score=0.
REQ-013 mem_addr SHALL equal eng_addr + base_q (modulo 2^ADDR_WIDTH, combinational) in all states.
REQ-014 SCAN SHALL last exactly NUM_CLASSES cycles; out_idx is registered, steps 0..NUM_CLASSES-1, and eng_out is sampled in the same cycle as the corresponding out_idx.
REQ-015 Comparison SHALL be signed and strict (eng_out > best); ties keep the lower index.
REQ-016 After sampling index NUM_CLASSES-1, the FSM SHALL enter RESULT; res_valid SHALL rise the following cycle edge with res_class/res_score of the final best, res_err=0.
REQ-017 In RESULT, res_valid=1 and res_class/res_score/res_err SHALL be held stable until res_valid&&res_ready, then the next state SHALL be IDLE.
REQ-018 A new req SHALL NOT be accepted in the cycle of the result handshake; earliest accept is the first IDLE cycle.
REQ-019 Latency SHALL be: accept edge to res_valid = 3 + W + NUM_CLASSES cycles, W = cycles spent in WAIT (min 1).
REQ-020 out_idx SHALL be 0 outside SCAN.

Reset
REQ-021 With rst=0 at a clock edge, state SHALL become IDLE, busy=0, eng_reset=0, eng_start=0, out_idx=0, res_valid=0, res_class=0, res_score=0, res_err=0, base_q=0, counter=0.
REQ-022 Reset asserted in any state, including mid-SCAN or RESULT awaiting ready, SHALL abort the operation with no further eng_start and no res_valid.

Verification
REQ-023 Nominal: img_base=0x00310, eng_done after 50 cycles, scores {-5,3,100,7,-200,99,0,1,2,4} -> res_class=2, res_score=100, res_err=0, res_valid 63 cycles after accept.
REQ-024 Tie and negatives: scores all -300 except idx3=idx7=-10 -> res_class=3, res_score=-10; all equal -16384 -> res_class=0.
REQ-025 Timeout: TIMEOUT=16, eng_done never asserted -> res_valid with res_err=1, res_class=15, res_score=0; eng_start pulsed exactly once.
REQ-026 Backpressure: res_ready=0 for 20 cycles -> outputs stable, req during that window ignored; accept occurs only after handshake plus one IDLE cycle.
REQ-027 Address: base_q=0x1FFF0, eng_addr=0x00020 -> mem_addr=0x00010 (wrap); img_base changes after accept do not affect mem_addr.
REQ-028 Reset mid-SCAN at out_idx=5 -> next cycle busy=0, out_idx=0, res_valid=0; a subsequent req completes normally.

Source files
------------

// File: rtl/dnn_classify_ctrl.sv
`timescale 1ns/1ps
// Classification controller: clears and starts the DNN engine, waits for
// completion (with timeout), scans the engine outputs and reports the argmax.
module dnn_classify_ctrl #(
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 15,
  parameter int NUM_CLASSES = 10,
  parameter int TIMEOUT     = 1000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic [ADDR_WIDTH-1:0]        img_base,
  output logic                         busy,
  output logic                         eng_reset,
  output logic                         eng_start,
  input  logic                         eng_done,
  input  logic [ADDR_WIDTH-1:0]        eng_addr,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [3:0]                   out_idx,
  input  logic signed [DATA_WIDTH-1:0] eng_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [3:0]                   res_class,
  output logic signed [DATA_WIDTH-1:0] res_score,
  output logic                         res_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SCAN   = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);
  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [2:0]                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]        base_q, base_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [3:0]                   idx_q, idx_d;
  logic [3:0]                   best_idx_q, best_idx_d;
  logic signed [DATA_WIDTH-1:0] best_score_q, best_score_d;
  logic                         res_valid_q, res_valid_d;
  logic [3:0]                   res_class_q, res_class_d;
  logic signed [DATA_WIDTH-1:0] res_score_q, res_score_d;
  logic                         res_err_q, res_err_d;

  logic                         better;
  logic [3:0]                   cand_idx;
  logic signed [DATA_WIDTH-1:0] cand_score;

  // Strict compare so a tie keeps the earlier (lower) index.
  assign better     = eng_out > best_score_q;
  assign cand_idx   = better ? idx_q : best_idx_q;
  assign cand_score = better ? eng_out : best_score_q;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    res_valid_d  = res_valid_q;
    res_class_d  = res_class_q;
    res_score_d  = res_score_q;
    res_err_d    = res_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          base_d  = img_base;
          state_d = S_CLR;
        end
      end
      S_CLR: state_d = S_START;
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) begin
          state_d      = S_SCAN;
          idx_d        = '0;
          best_idx_d   = '0;
          best_score_d = MOST_NEG;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_RESULT;
          res_class_d = 4'hF;
          res_score_d = '0;
          res_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SCAN: begin
        best_idx_d   = cand_idx;
        best_score_d = cand_score;
        if (idx_q == LAST_IDX) begin
          state_d     = S_RESULT;
          idx_d       = '0;
          res_class_d = cand_idx;
          res_score_d = cand_score;
          res_err_d   = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_RESULT: begin
        if (res_valid_q && res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      res_valid_q  <= 1'b0;
      res_class_q  <= '0;
      res_score_q  <= '0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      res_valid_q  <= res_valid_d;
      res_class_q  <= res_class_d;
      res_score_q  <= res_score_d;
      res_err_q    <= res_err_d;
    end
  end

  assign busy      = state_q != S_IDLE;
  assign eng_reset = state_q == S_CLR;
  assign eng_start = state_q == S_START;
  assign mem_addr  = eng_addr + base_q;
  assign out_idx   = idx_q;
  assign res_valid = res_valid_q;
  assign res_class = res_class_q;
  assign res_score = res_score_q;
  assign res_err   = res_err_q;

endmodule
